sparse_row_accumulator: RTL
===========================

# sparse_row_accumulator

Final stage of the sparse matrix–vector datapath. It sits directly downstream of the level-4 ALU and consumes its 4-lane partial-sum beat (lane data, 28 bits each). It carries running sums across beats, closes rows on per-lane end-of-row marks and queues completed row results in an internal FIFO. Results leave on a valid/ready stream.

## Interface
- `k`, 4: lanes per beat.
- `IN_W`, 28: lane width, signed.
- `ACC_W`, 32: accumulator and result width, signed.
- `DEPTH`, 8: result FIFO entries; power of two, ≥ 2*k.
- `ROW_W`, 16: row index width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  input beat present.
- `in_ready`  out  1  accumulator can take a beat.
- `in_data`  in  IN_W*k  lane partial sums; lane 0 = `[IN_W*k-1 : IN_W*(k-1)]`.
- `in_mask`  in  k  lane i carries a valid partial sum (bit k-1 = lane 0).
- `in_last`  in  k  lane i closes the current row after its addition.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer takes head.
- `out_sum`  out  ACC_W  completed row sum.
- `out_row`  out  ROW_W  row index of `out_sum`.
- `acc_pending`  out  1  running sum holds contributions of an unclosed row.
- `ovf`  out  1  sticky overflow flag.

## Operation
- An input beat is accepted when `in_valid && in_ready`. Lanes are processed in order, lane 0 to lane k-1, within that single cycle:
  - if `mask[i]`: `run += sext(lane_i)` to ACC_W;
  - if `last[i]`: push `{run, row_cnt}` to the FIFO, `row_cnt++`, `run = 0`.
- `last[i]` with `mask[i]=0` is legal. It closes the row with the current `run`, and an empty row emits 0.
- Pushes from one beat enter the FIFO in lane order. A beat pushes 0..k entries.
- The running accumulator register `acc` holds `run` after the beat; it is unchanged when no beat is accepted.
- `acc_pending` is 1 when at least one masked lane has been added since the last row close.
- `in_ready = (DEPTH - count) >= k`. It is combinational from the registered count, and a same-cycle pop is not credited.
- Pop occurs when `out_valid && out_ready`.
- On a simultaneous push and pop, `count_next = count + pushes - pop`. Head ordering is preserved.
- `row_cnt` wraps from 2^ROW_W-1 to 0 with no flag.
- An addition overflowing ACC_W signed sets `ovf`. `ovf` clears only on reset.
- Reset mid-row discards `acc`, the FIFO contents and `row_cnt`; no partial row is emitted.

## Timing
- Reset values:
  - `in_ready` = 1, `out_valid` = 0, `out_sum` = 0, `out_row` = 0, `acc_pending` = 0, `ovf` = 0;
  - `acc` = 0, `row_cnt` = 0, count = 0.
- Latency: a row closed in an accepted beat at edge N gives `out_valid` = 1 from cycle N+1. The FIFO is show-ahead.
- `out_sum` and `out_row` are stable while `out_valid && !out_ready`.
- Throughput: one beat per cycle while FIFO free ≥ k; one result popped per cycle.
- Full FIFO: `in_ready` = 0. Beats are held upstream and no data is lost.
- Empty FIFO: `out_valid` = 0, and `out_sum`/`out_row` hold their last popped value.

## Configuration
- `SPARSE_ACC_SAT_EN` defined: each lane addition saturates to `+2^(ACC_W-1)-1` or `-2^(ACC_W-1)` and sets `ovf`.
- Macro undefined: additions wrap modulo 2^ACC_W and still set `ovf`.

## Structure
- A shared package holds:
  - default widths `k`, `IN_W`, `ACC_W`, `ROW_W`;
  - the result entry typedef `{sum, row}`;
  - a `sat_add` function returning sum and overflow.
- Sub-module `sparse_result_fifo`: a parameterized multi-push (0..k per cycle), single-pop, show-ahead FIFO with `count` output.
- The top-level contains the lane-sequenced accumulation, row counter and overflow logic.

## Test plan
- Row within one beat: data lanes 3, −5, 7, 2, `mask=1111`, `last=0001`. Response: one result, sum 7, row 0, and `acc_pending` = 0.
- Multi-beat row followed by a close:
  - Beat 1: lanes 10, 10, 10, 10, `mask=1111`, `last=0000`; `acc_pending` = 1.
  - Beat 2: lane 0 = 5, `mask=1000`, `last=1000`.
  - Response: sum 45, row 0.
- Four rows in one beat plus an empty row:
  - Beat 1: lanes 1, 2, 3, 4, `mask=1111`, `last=1111`. Response: rows 0..3 with sums 1, 2, 3, 4, in order.
  - Beat 2: `mask=0000`, `last=1000`. Response: row 4, sum 0.
- Backpressure: hold `out_ready`=0 and send two beats each with `last=1111`. Response:
  - after 8 entries `in_ready` = 0 and the third beat stalls;
  - when `out_ready` rises, the heads pop in order, and `in_ready` returns once count ≤ 4.
- Overflow: 80 beats each with all lanes = `2^27-1`, `mask=1111`, `last=0000`, then close the row (ACC_W=32). Response:
  - `ovf` = 1;
  - with `SPARSE_ACC_SAT_EN` the sum is `0x7FFFFFFF`;
  - without it the sum is the wrapped value.
- Reset mid-row: a partial sum is pending, then `rst`=0 for 1 cycle. Response: all outputs at reset values, and the next row emitted is row 0 containing only post-reset data.

Source files
------------

// File: rtl/sparse_row_accumulator_pkg.sv
// Shared widths, result entry type and the lane adder for the sparse row accumulator.
// SPARSE_ACC_SAT_EN selects saturating lane additions; otherwise they wrap.
package sparse_row_accumulator_pkg;

  localparam int DEF_K     = 4;
  localparam int DEF_IN_W  = 28;
  localparam int DEF_ACC_W = 32;
  localparam int DEF_ROW_W = 16;
  localparam int DEF_DEPTH = 8;

  typedef struct packed {
    logic signed [DEF_ACC_W-1:0] sum;
    logic [DEF_ROW_W-1:0]        row;
  } res_t;

  typedef struct packed {
    logic signed [DEF_ACC_W-1:0] sum;
    logic                        ovf;
  } add_t;

  function automatic add_t sat_add(input logic signed [DEF_ACC_W-1:0] a,
                                   input logic signed [DEF_ACC_W-1:0] b);
    logic [DEF_ACC_W:0] full;
    add_t res;
    full    = {a[DEF_ACC_W-1], a} + {b[DEF_ACC_W-1], b};
    res.ovf = full[DEF_ACC_W] ^ full[DEF_ACC_W-1];
`ifdef SPARSE_ACC_SAT_EN
    // Sign of the extended sum tells which rail the result clipped against.
    if (res.ovf)
      res.sum = full[DEF_ACC_W] ? {1'b1, {(DEF_ACC_W-1){1'b0}}} : {1'b0, {(DEF_ACC_W-1){1'b1}}};
    else
      res.sum = full[DEF_ACC_W-1:0];
`else
    res.sum = full[DEF_ACC_W-1:0];
`endif
    return res;
  endfunction

endpackage

// File: rtl/sparse_row_accumulator_if.sv
// Beat input / result output stream bundle of the sparse row accumulator.
interface sparse_row_accumulator_if
  import sparse_row_accumulator_pkg::*;
#(
  parameter int k     = DEF_K,
  parameter int IN_W  = DEF_IN_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int ROW_W = DEF_ROW_W
) ();
  logic                    in_valid;
  logic                    in_ready;
  logic [IN_W*k-1:0]       in_data;
  logic [k-1:0]            in_mask;
  logic [k-1:0]            in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_sum;
  logic [ROW_W-1:0]        out_row;
  logic                    acc_pending;
  logic                    ovf;

  modport slave (
    input  in_valid, in_data, in_mask, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_row, acc_pending, ovf
  );

  modport master (
    output in_valid, in_data, in_mask, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_row, acc_pending, ovf
  );
endinterface

// File: rtl/sparse_row_accumulator_fifo.sv
// Show-ahead result FIFO: 0..NPUSH writes and one read per cycle, exposes its fill count.
// When empty the head output keeps the last popped entry.
module sparse_result_fifo #(
  parameter type T        = logic [31:0],
  parameter int  DEPTH    = 8,
  parameter int  NPUSH    = 4,
  localparam int AW       = $clog2(DEPTH),
  localparam int PW       = $clog2(NPUSH+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [PW-1:0] i_push_n,
  input  T              i_push_dat [NPUSH],
  input  logic          i_pop,
  output T              o_head,
  output logic [AW:0]   o_count
);
  T              r_mem [DEPTH];
  T              r_last;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  always_ff @(posedge clk) begin
    for (int j = 0; j < NPUSH; j++)
      if (PW'(j) < i_push_n)
        r_mem[r_wptr + AW'(j)] <= i_push_dat[j];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_last  <= '0;
    end else begin
      r_wptr  <= r_wptr + AW'(i_push_n);
      r_count <= r_count + (AW+1)'(i_push_n) - (AW+1)'(i_pop);
      if (i_pop) begin
        r_rptr <= r_rptr + AW'(1);
        r_last <= r_mem[r_rptr];
      end
    end
  end

  assign o_head  = (r_count != '0) ? r_mem[r_rptr] : r_last;
  assign o_count = r_count;
endmodule

// File: rtl/sparse_row_accumulator.sv
// Carries lane partial sums across beats, closes rows on end-of-row marks, queues results.
// SPARSE_ACC_SAT_EN makes lane additions saturate; default build wraps. Both set ovf.
module sparse_row_accumulator
  import sparse_row_accumulator_pkg::*;
#(
  parameter int k     = DEF_K,
  parameter int IN_W  = DEF_IN_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int ROW_W = DEF_ROW_W
) (
  input  logic                      clk,
  input  logic                      rst,
  sparse_row_accumulator_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(k+1);

  logic signed [ACC_W-1:0] r_acc;
  logic [ROW_W-1:0]        r_row;
  logic                    r_pend;
  logic                    r_ovf;

  logic signed [ACC_W-1:0] w_run;
  logic signed [ACC_W-1:0] w_lane;
  logic [ROW_W-1:0]        w_row;
  logic                    w_pend;
  logic                    w_ovf;
  add_t                    w_add;
  logic [PW-1:0]           w_push_n;
  logic [PW-1:0]           w_push_cnt;
  res_t                    w_push_dat [k];
  res_t                    w_head;
  logic [AW:0]             w_count;
  logic                    w_accept;
  logic                    w_pop;

  // Lanes are walked lane 0 first; lane 0 sits in the top slice and the top mask bit.
  always_comb begin
    w_run    = r_acc;
    w_row    = r_row;
    w_pend   = r_pend;
    w_ovf    = 1'b0;
    w_lane   = '0;
    w_add    = '0;
    w_push_n = '0;
    for (int j = 0; j < k; j++)
      w_push_dat[j] = '0;
    for (int i = 0; i < k; i++) begin
      if (bus.in_mask[k-1-i]) begin
        w_lane = {{(ACC_W-IN_W){bus.in_data[IN_W*(k-i)-1]}}, bus.in_data[IN_W*(k-i)-1 -: IN_W]};
        w_add  = sat_add(w_run, w_lane);
        w_run  = w_add.sum;
        w_ovf  = w_ovf | w_add.ovf;
        w_pend = 1'b1;
      end
      if (bus.in_last[k-1-i]) begin
        for (int j = 0; j < k; j++)
          if (PW'(j) == w_push_n)
            w_push_dat[j] = '{sum: w_run, row: w_row};
        w_push_n = w_push_n + PW'(1);
        w_row    = w_row + ROW_W'(1);
        w_run    = '0;
        w_pend   = 1'b0;
      end
    end
  end

  assign w_accept   = bus.in_valid && bus.in_ready;
  assign w_push_cnt = w_accept ? w_push_n : '0;
  assign w_pop      = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_acc  <= '0;
      r_row  <= '0;
      r_pend <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_accept) begin
      r_acc  <= w_run;
      r_row  <= w_row;
      r_pend <= w_pend;
      r_ovf  <= r_ovf | w_ovf;
    end
  end

  sparse_result_fifo #(
    .T     (res_t),
    .DEPTH (DEPTH),
    .NPUSH (k)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push_n   (w_push_cnt),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_count    (w_count)
  );

  // Credit is judged on the registered count only; a pop this cycle frees room next cycle.
  assign bus.in_ready    = (w_count <= (AW+1)'(DEPTH - k));
  assign bus.out_valid   = (w_count != '0);
  assign bus.out_sum     = w_head.sum;
  assign bus.out_row     = w_head.row;
  assign bus.acc_pending = r_pend;
  assign bus.ovf         = r_ovf;
endmodule
